// File: rtl/dds_iq_demod.sv
// Coherent I/Q demodulator: ADC samples times the DDS sine/cosine LO, summed over a window
// of N valid samples and emitted as one saturated I/Q pair with a single-cycle valid strobe.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero window length
// RUN    | accepting valid samples until the window count is exhausted
// FLUSH1 | draining the sample/product pipeline
// FLUSH2 | draining the product/accumulate pipeline
// DONE   | accumulators final; outputs register on leaving this state
module dds_iq_demod #(
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [15:0]        n_samples_i,
  input  logic signed [15:0] adc_data_i,
  input  logic               adc_valid_i,
  input  logic signed [15:0] lo_sin_i,
  input  logic signed [15:0] lo_cos_i,
  output logic [31:0]        i_out_o,
  output logic [31:0]        q_out_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               overflow_o
);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH1, FLUSH2, DONE} state_t;

  state_t                    state_q, state_d;
  logic [15:0]               rem_q, rem_d;
  logic                      v0_q, v0_d, v1_q, v1_d;
  logic signed [15:0]        adc_q, adc_d, sin_q, sin_d, cos_q, cos_d;
  logic signed [31:0]        prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [31:0]               i_out_q, i_out_d, q_out_q, q_out_d;
  logic                      out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic                      go, accept, load_out;
  logic [32:0]               i_sat, q_sat;

  // Bit 32 flags saturation; bits 31:0 are the clamped, shifted result.
  function automatic logic [32:0] sat32(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    v = a >>> OUT_SHIFT;
    if (v[ACC_W-1:31] == {(ACC_W-31){v[31]}}) sat32 = {1'b0, v[31:0]};
    else if (v[ACC_W-1])                      sat32 = {1'b1, 32'h8000_0000};
    else                                      sat32 = {1'b1, 32'h7FFF_FFFF};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // RUN leaves one cycle after the count is exhausted, giving the fixed 4-clock result latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && n_samples_i != 16'd0) state_d = RUN;
      RUN:     if (rem_q == 16'd0) state_d = FLUSH1;
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    go       = (state_q == IDLE) && start_i && (n_samples_i != 16'd0);
    accept   = (state_q == RUN) && adc_valid_i && (rem_q != 16'd0);
    load_out = (state_q == DONE);
    busy_o   = (state_q != IDLE);
  end

  always_comb begin
    i_sat       = sat32(acc_i_q);
    q_sat       = sat32(acc_q_q);
    rem_d       = rem_q;
    if (go)          rem_d = n_samples_i;
    else if (accept) rem_d = rem_q - 16'd1;
    v0_d        = accept;
    adc_d       = accept ? adc_data_i : adc_q;
    sin_d       = accept ? lo_sin_i   : sin_q;
    cos_d       = accept ? lo_cos_i   : cos_q;
    v1_d        = v0_q;
    prod_i_d    = v0_q ? 32'(adc_q) * 32'(cos_q) : prod_i_q;
    prod_q_d    = v0_q ? 32'(adc_q) * 32'(sin_q) : prod_q_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    if (go) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (v1_q) begin
      acc_i_d = acc_i_q + ACC_W'(prod_i_q);
      acc_q_d = acc_q_q + ACC_W'(prod_q_q);
    end
    out_valid_d = load_out;
    i_out_d     = load_out ? i_sat[31:0] : i_out_q;
    q_out_d     = load_out ? q_sat[31:0] : q_out_q;
    overflow_d  = load_out ? (i_sat[32] | q_sat[32]) : overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      adc_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      prod_i_q    <= '0;
      prod_q_q    <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      adc_q       <= adc_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      prod_i_q    <= prod_i_d;
      prod_q_q    <= prod_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      out_valid_q <= out_valid_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign i_out_o     = i_out_q;
  assign q_out_o     = q_out_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_dds_iq_demod.sv
// Bench for dds_iq_demod: two instances (OUT_SHIFT 16 and 0) share stimulus; a window table
// feeds a scoreboard checked on out_valid, plus hand-written control and reset sequences.
module tb_dds_iq_demod;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_i;
  logic [15:0]        n_samples_i;
  logic signed [15:0] adc_data_i, lo_sin_i, lo_cos_i;
  logic               adc_valid_i;
  logic [31:0]        i16, q16, i0, q0;
  logic               ov16, ov0, busy16, busy0, of16, of0;

  always #5 clk = ~clk;

  dds_iq_demod u_dut16 (
    .clk(clk), .reset(reset), .start_i(start_i), .n_samples_i(n_samples_i),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .lo_sin_i(lo_sin_i), .lo_cos_i(lo_cos_i),
    .i_out_o(i16), .q_out_o(q16), .out_valid_o(ov16), .busy_o(busy16), .overflow_o(of16)
  );

  dds_iq_demod #(.ACC_W(48), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start_i(start_i), .n_samples_i(n_samples_i),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .lo_sin_i(lo_sin_i), .lo_cos_i(lo_cos_i),
    .i_out_o(i0), .q_out_o(q0), .out_valid_o(ov0), .busy_o(busy0), .overflow_o(of0)
  );

  typedef struct {
    logic signed [15:0] adc;
    logic signed [15:0] sn;
    logic signed [15:0] cs;
    logic [15:0]        n;
    bit                 gap;
    logic [31:0]        ei16;
    logic [31:0]        eq16;
    bit                 eof16;
    logic [31:0]        ei0;
    logic [31:0]        eq0;
    bit                 eof0;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Results are popped and compared as they appear.
  always @(negedge clk) begin
    if (!reset && (ov16 || ov0)) begin
      vec_t e;
      pulses++;
      chk("valid_pair", {31'd0, ov0}, {31'd0, ov16});
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("i_out_s16", i16, e.ei16);
        chk("q_out_s16", q16, e.eq16);
        chk("ovf_s16", {31'd0, of16}, {31'd0, e.eof16});
        chk("i_out_s0", i0, e.ei0);
        chk("q_out_s0", q0, e.eq0);
        chk("ovf_s0", {31'd0, of0}, {31'd0, e.eof0});
      end
    end
  end

  // Entered and left #1 after a rising edge.
  task automatic run_window(input vec_t v, input bit b2b, input bit restart_mid);
    int acc;
    int k;
    start_i     = 1'b1;
    n_samples_i = v.n;
    adc_valid_i = 1'b0;
    sb.push_back(v);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_at_start", {31'd0, busy16}, 32'd1);
    acc = 0;
    k   = 0;
    while (acc < int'(v.n)) begin
      adc_data_i  = v.adc;
      lo_sin_i    = v.sn;
      lo_cos_i    = v.cs;
      adc_valid_i = (v.gap && (k % 2 == 1)) ? 1'b0 : 1'b1;
      if (restart_mid && k == 2) begin
        start_i     = 1'b1;
        n_samples_i = 16'd7;
      end
      @(posedge clk); #1;
      if (adc_valid_i) acc++;
      start_i = 1'b0;
      k++;
      chk("busy_in_window", {31'd0, busy16}, 32'd1);
    end
    adc_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c < 4) begin
        chk("early_out_valid", {31'd0, ov16}, 32'd0);
        chk("busy_flush", {31'd0, busy16}, 32'd1);
      end else begin
        chk("out_valid_latency", {31'd0, ov16}, 32'd1);
        chk("busy_fall", {31'd0, busy16}, 32'd0);
      end
    end
    if (!b2b) begin
      @(posedge clk); #1;
      chk("out_valid_width", {31'd0, ov16}, 32'd0);
    end
  endtask

  initial begin
    int p;
    vecs[0] = '{16384, 0, 16384, 16'd4, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 32'h4000_0000, 32'h0, 1'b0};
    vecs[1] = '{-16384, 16384, 0, 16'd4, 1'b0, 32'h0, 32'hFFFF_C000, 1'b0, 32'h0, 32'hC000_0000, 1'b0};
    vecs[2] = '{16384, 0, 16384, 16'd4, 1'b1, 32'h0000_4000, 32'h0, 1'b0, 32'h4000_0000, 32'h0, 1'b0};
    vecs[3] = '{-32768, 0, -32768, 16'd4, 1'b0, 32'h0001_0000, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1};
    vecs[4] = '{0, 0, -32768, 16'd4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{100, 300, -200, 16'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'hFFFF_B1E0, 32'h0000_7530, 1'b0};
    vecs[6] = '{-32768, -32768, 32767, 16'd3, 1'b0, 32'hFFFF_4001, 32'h0000_C000, 1'b0,
                32'h8000_0000, 32'h7FFF_FFFF, 1'b1};

    reset = 1'b1; start_i = 1'b0; n_samples_i = '0; adc_valid_i = 1'b0;
    adc_data_i = '0; lo_sin_i = '0; lo_cos_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_out", i16, 32'h0);
    chk("rst_q_out", q16, 32'h0);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_overflow", {31'd0, of0}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_window(vecs[i], (i == 0), 1'b0);

    // Zero-length start is ignored even with samples present.
    p = pulses;
    start_i = 1'b1; n_samples_i = 16'd0; adc_valid_i = 1'b1; adc_data_i = 16'sd1000;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("n0_busy", {31'd0, busy16}, 32'd0);
    end
    start_i = 1'b0; adc_valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("n0_no_out_valid", pulses, p);

    // Second start mid-window must not restart or add a result.
    p = pulses;
    run_window(vecs[0], 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("restart_single_pulse", pulses, p + 1);

    // Reset after 2 of 8 samples; previous outputs (negative saturation) are non-zero.
    run_window(vecs[6], 1'b0, 1'b0);
    p = pulses;
    start_i = 1'b1; n_samples_i = 16'd8; adc_valid_i = 1'b0;
    adc_data_i = 16'sd16384; lo_cos_i = 16'sd16384; lo_sin_i = 16'sd0;
    @(posedge clk); #1;
    start_i = 1'b0; adc_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_i16", i16, 32'h0);
    chk("midrst_q16", q16, 32'h0);
    chk("midrst_i0", i0, 32'h0);
    chk("midrst_ovf0", {31'd0, of0}, 32'd0);
    chk("midrst_busy", {31'd0, busy16}, 32'd0);
    chk("midrst_out_valid", {31'd0, ov16}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_idle", {31'd0, busy16}, 32'd0);
    adc_valid_i = 1'b0;
    chk("midrst_no_out_valid", pulses, p);
    run_window(vecs[0], 1'b0, 1'b0);
    run_window(vecs[1], 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_iq_demod.md
# dds_iq_demod

Receive-side counterpart of the DDS slave core: coherent I/Q demodulator for the LLRF loop. ADC samples are multiplied by the sine/cosine local-oscillator samples produced by the DDS path, and the products are accumulated over a programmable window of N valid samples. At the end of the window the block emits one registered I/Q pair with a single-cycle valid strobe. It sits between the ADC capture logic and the amplitude/phase control loop.

## Interface
- ACC_W, 48: accumulator width in bits, signed.
- OUT_SHIFT, 16: arithmetic right shift applied to the accumulator before output saturation.
- clk  in  1  system clock; the same clock that drives the DDS core.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  starts a measurement window; sampled only in IDLE.
- n_samples  in  16  window length in valid samples; latched on an accepted start.
- adc_data  in  16  signed ADC sample.
- adc_valid  in  1  qualifies adc_data, lo_sin and lo_cos in the same cycle.
- lo_sin  in  16  signed LO sine sample, time-aligned with adc_data.
- lo_cos  in  16  signed LO cosine sample, time-aligned with adc_data.
- i_out  out  32  signed in-phase result; holds its value until the next result.
- q_out  out  32  signed quadrature result; holds its value until the next result.
- out_valid  out  1  one-cycle pulse when i_out and q_out are updated.
- busy  out  1  high while a window is in progress (state != IDLE).
- overflow  out  1  saturation flag for the last result; updated together with out_valid.

## Operation
- States: IDLE, RUN, FLUSH1, FLUSH2, DONE.
- IDLE
  - start=1 with n_samples!=0: latch n_samples, clear both accumulators and the sample counter, go to RUN.
  - start=1 with n_samples=0: ignored; stay in IDLE.
- RUN
  - Each cycle with adc_valid=1 accepts one sample and increments the counter.
  - Cycles with adc_valid=0 are not counted and are not accumulated.
  - When the accepted sample is number n_samples, go to FLUSH1.
- FLUSH1 -> FLUSH2 -> DONE: unconditional, one cycle each. These cycles drain the pipeline.
- DONE: register the outputs, pulse out_valid, go to IDLE.
- Pipeline:
  - P0: register adc_data, lo_sin and lo_cos on an accepted sample.
  - P1: prod_i = adc*lo_cos and prod_q = adc*lo_sin, each signed 32-bit, registered. (-32768 * -32768 = 2^30 fits.)
  - P2: acc_i += sign-extended prod_i and acc_q += sign-extended prod_q, both ACC_W bits.
- Output arithmetic:
  - v = acc >>> OUT_SHIFT, an arithmetic shift (floor).
  - If v > 2^31-1, output 0x7FFFFFFF; if v < -2^31, output 0x80000000.
  - overflow = 1 if either I or Q saturated, else 0.
- start while busy: ignored. A window in progress is never restarted.
- adc_valid and start in IDLE: no effect; samples are accepted only in RUN.
- reset, at any time including mid-window:
  - state = IDLE; counter, accumulators and pipeline registers cleared.
  - i_out = 0, q_out = 0, out_valid = 0, busy = 0, overflow = 0.
  - The partial window is discarded and no out_valid is issued.

## Timing
- start is accepted at edge S; busy is high from S.
- The last sample of the window is accepted at edge E.
- i_out, q_out, overflow and out_valid update at edge E+4. This is a fixed latency of 4 clocks from the last accepted sample.
- busy falls at the same edge that raises out_valid (E+4).
- out_valid is high for exactly one cycle.
- A start presented in the out_valid cycle is accepted: state is IDLE at that point.
- Minimum window: n_samples=1 with adc_valid held high. The sample is accepted at S+1 and the result appears at S+5.
- Counter is 16 bits; n_samples=65535 is supported without wrap.
- Worst-case accumulation is 65535 * 2^30 < 2^46, so a 48-bit accumulator never wraps.

## Test plan
- DC in-phase check:
  - Stimulus: adc_data=16384, lo_cos=16384, lo_sin=0, n_samples=4, adc_valid continuously high.
  - Response: i_out=0x00004000, q_out=0, overflow=0; out_valid exactly 4 clocks after the 4th accepted sample.
- Quadrature sign check:
  - Stimulus: adc_data=-16384, lo_sin=16384, lo_cos=0, n_samples=4.
  - Response: q_out=0xFFFFC000, i_out=0.
- Gapped valid:
  - Stimulus: same as the DC check, with adc_valid toggling 1,0,1,0,...
  - Response: identical result; out_valid 4 clocks after the 4th valid sample; busy high throughout the window.
- Saturation, OUT_SHIFT=0:
  - Stimulus: adc_data=-32768, lo_cos=-32768, n_samples=4.
  - Response: accumulator = 2^32, so i_out=0x7FFFFFFF, overflow=1.
  - Follow-up: a next window with adc_data=0 gives i_out=0 and clears overflow.
- Control corner cases:
  - start with n_samples=0 -> busy stays 0 and no out_valid.
  - Second start pulse mid-window -> ignored; exactly one out_valid for the first window.
- Reset mid-window:
  - Stimulus: assert reset after 2 of 8 samples.
  - Response: all outputs 0 immediately; no out_valid.
  - A fresh window after reset produces a correct result with no residue from the aborted window.
